// File: rtl/fp_dot_seq.sv
// Dot-product sequencer in front of a shared single-precision fp_alu.
// Each operand pair takes one multiply cycle and then one accumulate cycle.
module fp_dot_seq #(
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [1:0]       alu_op,
  input  logic [31:0]      alu_out,
  output logic             done,
  output logic [31:0]      result
);

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpMul = 2'b10;

  typedef enum logic [1:0] {StIdle, StMul, StAdd, StDone} state_e;

  state_e           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      prod_q, prod_d;
  logic [31:0]      result_q, result_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + LEN_W'(1);
  assign result  = result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      prod_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    busy     = 1'b1;
    in_ready = 1'b0;
    done     = 1'b0;
    alu_a    = '0;
    alu_b    = '0;
    alu_op   = OpAdd;

    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          len_d   = len;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = (len != '0) ? StMul : StDone;
        end
      end
      StMul: begin
        in_ready = 1'b1;
        alu_a    = in_a;
        alu_b    = in_b;
        alu_op   = OpMul;
        if (in_valid) begin
          prod_d  = alu_out;
          state_d = StAdd;
        end
      end
      StAdd: begin
        alu_a   = acc_q;
        alu_b   = prod_q;
        alu_op  = OpAdd;
        acc_d   = alu_out;
        cnt_d   = cnt_inc;
        // len_q is never 0 here, so the count cannot wrap before matching
        state_d = (cnt_inc == len_q) ? StDone : StMul;
      end
      StDone: begin
        done     = 1'b1;
        result_d = acc_q;
        state_d  = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_fp_dot_seq.sv
// Bench for fp_dot_seq: a real-arithmetic fp_alu stand-in plus a reference
// dot product over exactly representable operands.
module tb_fp_dot_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic [31:0] alu_a, alu_b;
  logic [1:0]  alu_op;
  logic [31:0] alu_out;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  logic [31:0] pa[$];
  logic [31:0] pb[$];
  int          pst[$];
  logic [31:0] prev_result;

  fp_dot_seq #(.LEN_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .busy     (busy),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_out  (alu_out),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  // Normal numbers only; operands are chosen so every result is exact.
  function automatic real dec(input logic [31:0] b);
    real v;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    v = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return b[31] ? -v : v;
  endfunction

  function automatic logic [31:0] enc(input real x);
    logic       s;
    int         e;
    int         m;
    logic [7:0] ex;
    if (x == 0.0) return 32'h0;
    s = (x < 0.0);
    if (s) x = -x;
    e = 0;
    while (x >= 2.0) begin x = x / 2.0; e++; end
    while (x < 1.0) begin x = x * 2.0; e--; end
    m  = int'((x - 1.0) * 8388608.0);
    ex = 8'(e + 127);
    return {s, ex, m[22:0]};
  endfunction

  always_comb begin
    case (alu_op)
      2'b00:   alu_out = enc(dec(alu_a) + dec(alu_b));
      2'b01:   alu_out = enc(dec(alu_a) - dec(alu_b));
      2'b10:   alu_out = enc(dec(alu_a) * dec(alu_b));
      default: alu_out = alu_b;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic add_pair(input logic [31:0] a, input logic [31:0] b, input int stall);
    pa.push_back(a);
    pb.push_back(b);
    pst.push_back(stall);
  endtask

  task automatic clear_pairs();
    pa.delete();
    pb.delete();
    pst.delete();
  endtask

  // Runs one dot product on the queued pairs; call at a falling edge.
  // Cycle c is the cycle after rising edge c, with start sampled at edge 0.
  task automatic run_dot(input bit mid_start, input bit check_op, input string tag);
    int          n, p, s, tot, exp_cyc;
    real         sum;
    logic [31:0] exp_res;
    bit          xfer, xfer_prev, exp_rdy;
    n   = pa.size();
    sum = 0.0;
    tot = 0;
    for (int i = 0; i < n; i++) begin
      sum = sum + dec(pa[i]) * dec(pb[i]);
      tot = tot + pst[i];
    end
    exp_res = enc(sum);
    exp_cyc = 2 * n + 1 + tot;
    start    = 1'b1;
    len      = 8'(n);
    in_valid = 1'b0;
    @(posedge clk);
    p         = 0;
    s         = (n > 0) ? pst[0] : 0;
    xfer_prev = 1'b0;
    for (int c = 1; c <= exp_cyc + 1; c++) begin
      @(negedge clk);
      start = mid_start && (c == 1);
      len   = mid_start ? 8'd5 : 8'd0;
      if (c == 1) chk({tag, " result_held"}, result, prev_result);
      if (c <= exp_cyc) begin
        chk({tag, " done"}, 32'(done), 32'(c == exp_cyc));
        chk({tag, " busy"}, 32'(busy), 32'd1);
      end
      if (check_op && c == 1) chk({tag, " op_mul"}, 32'(alu_op), 32'd2);
      if (check_op && c == 2) chk({tag, " op_add"}, 32'(alu_op), 32'd0);
      // A pair is wanted while pairs remain, except the cycle after a transfer
      exp_rdy = (p < n) && !xfer_prev && (c < exp_cyc);
      chk({tag, " in_ready"}, 32'(in_ready), 32'(exp_rdy));
      if (c == exp_cyc + 1) begin
        chk({tag, " result"}, result, exp_res);
        chk({tag, " idle"}, 32'(busy), 32'd0);
      end
      xfer = exp_rdy && (s == 0);
      if (p < n) begin
        in_a = pa[p];
        in_b = pb[p];
      end else begin
        in_a = $urandom;
        in_b = $urandom;
      end
      if (xfer) in_valid = 1'b1;
      else if (exp_rdy) begin
        in_valid = 1'b0;
        s--;
      end else in_valid = 1'($urandom_range(0, 1));
      if (xfer) begin
        p++;
        s = (p < n) ? pst[p] : 0;
      end
      xfer_prev = xfer;
    end
    in_valid    = 1'b0;
    start       = 1'b0;
    len         = 8'd0;
    prev_result = exp_res;
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    len         = 8'd0;
    in_valid    = 1'b0;
    in_a        = 32'h0;
    in_b        = 32'h0;
    prev_result = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", result, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    clear_pairs();
    add_pair(32'h3F800000, 32'h40400000, 0);
    add_pair(32'h40000000, 32'h40800000, 0);
    run_dot(1'b0, 1'b0, "len2");
    chk("len2 const", result, 32'h41300000);

    clear_pairs();
    add_pair(32'h3FC00000, 32'hC0000000, 0);
    run_dot(1'b0, 1'b1, "len1");
    chk("len1 const", result, 32'hC0400000);

    clear_pairs();
    for (int i = 0; i < 3; i++) add_pair(32'h3F800000, 32'h3F800000, 2);
    run_dot(1'b0, 1'b0, "stall");
    chk("stall const", result, 32'h40400000);

    clear_pairs();
    run_dot(1'b0, 1'b0, "len0");
    chk("len0 const", result, 32'h0);

    clear_pairs();
    add_pair(32'h3F800000, 32'h40400000, 0);
    add_pair(32'h40000000, 32'h40800000, 0);
    run_dot(1'b1, 1'b0, "midstart");
    chk("midstart const", result, 32'h41300000);

    // Reset during the accumulate cycle of a two-pair run
    start    = 1'b1;
    len      = 8'd2;
    in_valid = 1'b1;
    in_a     = 32'h3F800000;
    in_b     = 32'h40400000;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_reset busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async busy", 32'(busy), 32'd0);
    chk("async in_ready", 32'(in_ready), 32'd0);
    chk("async done", 32'(done), 32'd0);
    chk("async result", result, 32'h0);
    chk("async alu_op", 32'(alu_op), 32'd0);
    chk("async alu_a", alu_a, 32'h0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n       = 1'b1;
    prev_result = 32'h0;
    @(negedge clk);
    clear_pairs();
    add_pair(32'h40000000, 32'h40000000, 0);
    run_dot(1'b0, 1'b0, "post_reset");
    chk("post_reset const", result, 32'h40800000);

    for (int r = 0; r < 6; r++) begin
      int n;
      clear_pairs();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        int ka, kb;
        ka = $urandom_range(0, 80) - 40;
        kb = $urandom_range(0, 80) - 40;
        add_pair(enc(real'(ka) / 4.0), enc(real'(kb) / 4.0), $urandom_range(0, 2));
      end
      run_dot(1'($urandom_range(0, 1)), 1'b0, $sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
